// File: rtl/stats_counter_ram_pkg.sv
// Shared definitions for the statistics counter RAM: FSM state encoding and
// the helpers that split a register byte address into index and word select.
package stats_counter_ram_pkg;

    typedef enum logic [1:0] {
        ST_INIT     = 2'd0,
        ST_IDLE     = 2'd1,
        ST_STAT_WR  = 2'd2,
        ST_REG_RESP = 2'd3
    } state_t;

    // Bit position of the low/high word select inside the byte address.
    function automatic int word_sel_bit(int reg_data_width);
        return $clog2(reg_data_width / 8);
    endfunction

    // Lowest bit of the counter index field (index occupies the address MSBs).
    function automatic int index_lsb(int reg_addr_width, int stat_id_width);
        return reg_addr_width - stat_id_width;
    endfunction

endpackage

// File: rtl/stats_ram_sp.sv
// Single-port distributed RAM: synchronous write, registered read.
module stats_ram_sp #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  we,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    output logic [DATA_WIDTH-1:0] rdata
);

    (* ram_style = "distributed" *)
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] rdata_d;

    // Storage array; contents are not reset, the owner clears them by sweeping.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Read port: hold the last read word unless a new read is requested.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[addr];
        end
    end

    // Read data register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/stats_counter_ram.sv
// Accumulates an increment stream into per-counter totals held in RAM and
// serves the totals over a 32-bit-style register read port. A low-word read
// snapshots the high word so a following high-word read of the same counter
// returns a coherent total even if the counter was updated in between.
module stats_counter_ram
    import stats_counter_ram_pkg::*;
#(
    parameter int STAT_INC_WIDTH   = 16,
    parameter int STAT_ID_WIDTH    = 5,
    parameter int REG_DATA_WIDTH   = 32,
    parameter int STAT_COUNT_WIDTH = 2 * REG_DATA_WIDTH,
    parameter int REG_ADDR_WIDTH   = STAT_ID_WIDTH + $clog2(STAT_COUNT_WIDTH / 8)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [STAT_INC_WIDTH-1:0] s_axis_stat_tdata,
    input  logic [STAT_ID_WIDTH-1:0]  s_axis_stat_tid,
    input  logic                      s_axis_stat_tvalid,
    output logic                      s_axis_stat_tready,
    input  logic [REG_ADDR_WIDTH-1:0] reg_rd_addr,
    input  logic                      reg_rd_en,
    output logic [REG_DATA_WIDTH-1:0] reg_rd_data,
    output logic                      reg_rd_wait,
    output logic                      reg_rd_ack
);

    localparam int WORD_BIT = word_sel_bit(REG_DATA_WIDTH);
    localparam int IDX_LSB  = index_lsb(REG_ADDR_WIDTH, STAT_ID_WIDTH);

    state_t                    state_q, state_d;
    logic [STAT_ID_WIDTH-1:0]  init_ptr_q, init_ptr_d;
    logic [STAT_ID_WIDTH-1:0]  id_q, id_d;
    logic [STAT_INC_WIDTH-1:0] inc_q, inc_d;
    logic [REG_DATA_WIDTH-1:0] shadow_q, shadow_d;
    logic [STAT_ID_WIDTH-1:0]  shadow_id_q, shadow_id_d;
    logic                      shadow_vld_q, shadow_vld_d;
    logic [REG_DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                      ack_q, ack_d;

    logic [STAT_ID_WIDTH-1:0]    ram_addr;
    logic                        ram_we;
    logic                        ram_re;
    logic [STAT_COUNT_WIDTH-1:0] ram_wdata;
    logic [STAT_COUNT_WIDTH-1:0] rd_reg;

    logic [STAT_ID_WIDTH-1:0]  rd_index;
    logic                      rd_word;
    logic                      rd_req;
    logic [REG_DATA_WIDTH-1:0] rd_low;
    logic [REG_DATA_WIDTH-1:0] rd_high;

    assign rd_index = reg_rd_addr[IDX_LSB +: STAT_ID_WIDTH];
    assign rd_word  = reg_rd_addr[WORD_BIT];
    assign rd_low   = rd_reg[REG_DATA_WIDTH-1:0];
    assign rd_high  = rd_reg[STAT_COUNT_WIDTH-1 -: REG_DATA_WIDTH];
    // The request stays high through the ack cycle; it is not a new request then.
    assign rd_req   = reg_rd_en && !ack_q;

    generate
        if (WORD_BIT > 0) begin : g_unused_addr
            logic unused_low_addr_bits;
            assign unused_low_addr_bits = ^reg_rd_addr[WORD_BIT-1:0];
        end
    endgenerate

    stats_ram_sp #(
        .DATA_WIDTH (STAT_COUNT_WIDTH),
        .ADDR_WIDTH (STAT_ID_WIDTH)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .addr  (ram_addr),
        .we    (ram_we),
        .wdata (ram_wdata),
        .re    (ram_re),
        .rdata (rd_reg)
    );

    // Next-state, RAM control and read-response logic.
    always_comb begin
        state_d            = state_q;
        init_ptr_d         = init_ptr_q;
        id_d               = id_q;
        inc_d              = inc_q;
        shadow_d           = shadow_q;
        shadow_id_d        = shadow_id_q;
        shadow_vld_d       = shadow_vld_q;
        rd_data_d          = rd_data_q;
        ack_d              = 1'b0;
        ram_addr           = id_q;
        ram_we             = 1'b0;
        ram_re             = 1'b0;
        ram_wdata          = rd_reg + STAT_COUNT_WIDTH'(inc_q);
        s_axis_stat_tready = 1'b0;
        case (state_q)
            ST_INIT: begin
                ram_addr   = init_ptr_q;
                ram_we     = 1'b1;
                ram_wdata  = '0;
                init_ptr_d = init_ptr_q + 1'b1;
                if (init_ptr_q == '1) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (rd_req) begin
                    ram_addr = rd_index;
                    ram_re   = 1'b1;
                    state_d  = ST_REG_RESP;
                end else begin
                    s_axis_stat_tready = 1'b1;
                    if (s_axis_stat_tvalid) begin
                        id_d     = s_axis_stat_tid;
                        inc_d    = s_axis_stat_tdata;
                        ram_addr = s_axis_stat_tid;
                        ram_re   = 1'b1;
                        state_d  = ST_STAT_WR;
                    end
                end
            end
            ST_STAT_WR: begin
                // Total wraps silently modulo the counter width.
                ram_addr = id_q;
                ram_we   = 1'b1;
                state_d  = ST_IDLE;
            end
            ST_REG_RESP: begin
                ack_d = 1'b1;
                if (!rd_word) begin
                    rd_data_d    = rd_low;
                    shadow_d     = rd_high;
                    shadow_id_d  = rd_index;
                    shadow_vld_d = 1'b1;
                end else if (shadow_vld_q && (shadow_id_q == rd_index)) begin
                    rd_data_d    = shadow_q;
                    shadow_vld_d = 1'b0;
                end else begin
                    rd_data_d    = rd_high;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_INIT;
            init_ptr_q   <= '0;
            id_q         <= '0;
            inc_q        <= '0;
            shadow_q     <= '0;
            shadow_id_q  <= '0;
            shadow_vld_q <= 1'b0;
            rd_data_q    <= '0;
            ack_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            init_ptr_q   <= init_ptr_d;
            id_q         <= id_d;
            inc_q        <= inc_d;
            shadow_q     <= shadow_d;
            shadow_id_q  <= shadow_id_d;
            shadow_vld_q <= shadow_vld_d;
            rd_data_q    <= rd_data_d;
            ack_q        <= ack_d;
        end
    end

    assign reg_rd_data = rd_data_q;
    assign reg_rd_ack  = ack_q;
    assign reg_rd_wait = reg_rd_en && !ack_q;

endmodule

// File: tb/tb_stats_counter_ram.sv
// Testbench for stats_counter_ram: three configurations share one stimulus
// bus (default, 8-bit register words, 32-bit increments).
module tb_stats_counter_ram;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] tdata;
    logic [4:0]  tid;
    logic        tvalid;
    logic [7:0]  addr;
    logic        rd_en;
    int          sel;

    logic [2:0]  tready_v, wait_v, ack_v;
    logic [31:0] rd0, rd2;
    logic [7:0]  rd1;

    int checks = 0;
    int errors = 0;

    // reference model: totals per instance, plus the snapshot register semantics
    longint unsigned model [3][32];
    logic [31:0]     shadow_m [3];
    int              shadow_id_m [3];
    bit              shadow_vld_m [3];
    int              rw_m [3] = '{32, 8, 32};
    int              cw_m [3] = '{64, 16, 64};
    int              wb_m [3] = '{2, 0, 2};

    typedef struct {
        int              inst;
        bit              is_rd;
        int              id;
        int              word;
        longint unsigned val;   // increment, or expected read data
    } vec_t;

    always #5 clk = ~clk;

    stats_counter_ram u0 (
        .clk(clk), .rst_n(rst_n),
        .s_axis_stat_tdata(tdata[15:0]), .s_axis_stat_tid(tid),
        .s_axis_stat_tvalid(tvalid && sel == 0), .s_axis_stat_tready(tready_v[0]),
        .reg_rd_addr(addr), .reg_rd_en(rd_en && sel == 0),
        .reg_rd_data(rd0), .reg_rd_wait(wait_v[0]), .reg_rd_ack(ack_v[0]));

    stats_counter_ram #(.REG_DATA_WIDTH(8)) u1 (
        .clk(clk), .rst_n(rst_n),
        .s_axis_stat_tdata(tdata[15:0]), .s_axis_stat_tid(tid),
        .s_axis_stat_tvalid(tvalid && sel == 1), .s_axis_stat_tready(tready_v[1]),
        .reg_rd_addr(addr[5:0]), .reg_rd_en(rd_en && sel == 1),
        .reg_rd_data(rd1), .reg_rd_wait(wait_v[1]), .reg_rd_ack(ack_v[1]));

    stats_counter_ram #(.STAT_INC_WIDTH(32)) u2 (
        .clk(clk), .rst_n(rst_n),
        .s_axis_stat_tdata(tdata), .s_axis_stat_tid(tid),
        .s_axis_stat_tvalid(tvalid && sel == 2), .s_axis_stat_tready(tready_v[2]),
        .reg_rd_addr(addr), .reg_rd_en(rd_en && sel == 2),
        .reg_rd_data(rd2), .reg_rd_wait(wait_v[2]), .reg_rd_ack(ack_v[2]));

    function automatic logic [31:0] rdata_of(int inst);
        case (inst)
            0:       return rd0;
            1:       return {24'd0, rd1};
            default: return rd2;
        endcase
    endfunction

    function automatic logic [7:0] addr_of(int inst, int idx, int word);
        int wb = wb_m[inst];
        return 8'((idx << (wb + 1)) | (word << wb));
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 32; j++) model[i][j] = 0;
            shadow_m[i] = 0;
            shadow_id_m[i] = 0;
            shadow_vld_m[i] = 0;
        end
    endfunction

    function automatic void model_inc(int inst, int idx, longint unsigned val);
        longint unsigned s = model[inst][idx] + val;
        if (cw_m[inst] < 64) s = s & ((64'd1 << cw_m[inst]) - 1);
        model[inst][idx] = s;
    endfunction

    function automatic logic [31:0] model_read(int inst, int idx, int word);
        longint unsigned v     = model[inst][idx];
        int              rw    = rw_m[inst];
        longint unsigned rmask = (64'd1 << rw) - 1;
        logic [31:0]     lo    = 32'(v & rmask);
        logic [31:0]     hi    = 32'((v >> rw) & rmask);
        if (word == 0) begin
            shadow_m[inst]     = hi;
            shadow_id_m[inst]  = idx;
            shadow_vld_m[inst] = 1;
            return lo;
        end
        if (shadow_vld_m[inst] && shadow_id_m[inst] == idx) begin
            shadow_vld_m[inst] = 0;
            return shadow_m[inst];
        end
        return hi;
    endfunction

    task automatic check(string name, longint unsigned act, longint unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_inc(int inst, int idx, longint unsigned val);
        bit acc = 0;
        sel = inst; tid = 5'(idx); tdata = val[31:0]; tvalid = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (tready_v[inst]) acc = 1;
            @(posedge clk); #1;
            if (acc) break;
        end
        tvalid = 1'b0;
        if (acc) model_inc(inst, idx, val);
        else check("inc_accept_timeout", 0, 1);
    endtask

    task automatic do_read(int inst, int idx, int word, output logic [31:0] data, output int lat);
        bit got = 0;
        data = 0;
        sel = inst; addr = addr_of(inst, idx, word); rd_en = 1'b1; lat = 0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk); #1;
            lat++;
            if (ack_v[inst]) begin
                data = rdata_of(inst); got = 1;
                break;
            end
        end
        rd_en = 1'b0;
        if (!got) check("read_ack_timeout", 0, 1);
    endtask

    task automatic read_check(int inst, int idx, int word, string name);
        logic [31:0] exp, act;
        int lat;
        exp = model_read(inst, idx, word);
        do_read(inst, idx, word, act, lat);
        $display("read  inst=%0d idx=%0d word=%0d data=0x%0h lat=%0d", inst, idx, word, act, lat);
        check(name, act, exp);
    endtask

    task automatic check_reset_outputs(string name);
        for (int i = 0; i < 3; i++) begin
            check({name, "_tready"}, tready_v[i], 0);
            check({name, "_wait"}, wait_v[i], 0);
            check({name, "_ack"}, ack_v[i], 0);
            check({name, "_data"}, rdata_of(i), 0);
        end
    endtask

    task automatic sweep_zero(string name);
        for (int i = 0; i < 32; i++) begin
            read_check(0, i, 0, name);
            read_check(0, i, 1, name);
        end
    endtask

    initial begin
        vec_t        vecs[$];
        logic [31:0] d;
        int          n, lat, acc_cnt;
        bit          got;

        vecs.push_back('{0, 0, 3, 0, 64'h10});
        vecs.push_back('{0, 0, 3, 0, 64'h5});
        vecs.push_back('{0, 1, 3, 0, 64'h15});
        vecs.push_back('{0, 1, 3, 1, 64'h0});
        vecs.push_back('{0, 0, 3, 0, 64'h0});
        vecs.push_back('{0, 1, 3, 0, 64'h15});
        vecs.push_back('{0, 0, 31, 0, 64'hFFFF});
        vecs.push_back('{0, 1, 31, 0, 64'hFFFF});
        vecs.push_back('{0, 1, 31, 1, 64'h0});
        vecs.push_back('{1, 0, 0, 0, 64'hFFFF});
        vecs.push_back('{1, 0, 0, 0, 64'h1});
        vecs.push_back('{1, 1, 0, 0, 64'h00});
        vecs.push_back('{1, 1, 0, 1, 64'h00});
        vecs.push_back('{1, 0, 0, 0, 64'h100});
        vecs.push_back('{1, 1, 0, 0, 64'h00});
        vecs.push_back('{1, 1, 0, 1, 64'h01});
        vecs.push_back('{2, 0, 5, 0, 64'hFFFF_FFF0});
        vecs.push_back('{2, 1, 5, 0, 64'hFFFF_FFF0});
        vecs.push_back('{2, 0, 5, 0, 64'h20});
        vecs.push_back('{2, 1, 5, 1, 64'h0});
        vecs.push_back('{2, 1, 5, 1, 64'h1});

        rst_n = 1'b0; tvalid = 1'b0; rd_en = 1'b0;
        tdata = '0; tid = '0; addr = '0; sel = 0;
        model_clear();

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");

        // init sweep length
        @(negedge clk); rst_n = 1'b1;
        n = 0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #1;
            n++;
            if (tready_v[0]) break;
        end
        $display("init  cycles=%0d", n);
        check("init_cycles", n, 32);
        check("init_done_u1", tready_v[1], 1);
        check("init_done_u2", tready_v[2], 1);
        sweep_zero("init_zero");

        // directed vectors
        foreach (vecs[k]) begin
            if (vecs[k].is_rd) begin
                logic [31:0] m;
                m = model_read(vecs[k].inst, vecs[k].id, vecs[k].word);
                do_read(vecs[k].inst, vecs[k].id, vecs[k].word, d, lat);
                $display("read  inst=%0d idx=%0d word=%0d data=0x%0h lat=%0d",
                         vecs[k].inst, vecs[k].id, vecs[k].word, d, lat);
                check("vec_read", d, vecs[k].val);
                check("vec_model", m, vecs[k].val);
            end else begin
                do_inc(vecs[k].inst, vecs[k].id, vecs[k].val);
                $display("inc   inst=%0d id=%0d val=0x%0h", vecs[k].inst, vecs[k].id, vecs[k].val);
            end
        end

        // contention: increment stream to id 7 with a read slotted in mid-stream
        sel = 0; acc_cnt = 0;
        fork
            begin
                tid = 5'd7; tdata = 32'd1; tvalid = 1'b1;
                for (int c = 0; c < 200 && acc_cnt < 10; c++) begin
                    @(negedge clk);
                    if (tready_v[0]) acc_cnt++;
                    @(posedge clk); #1;
                end
                tvalid = 1'b0;
            end
            begin
                logic [31:0] exp_c;
                for (int c = 0; c < 200; c++) begin
                    @(posedge clk);
                    if (acc_cnt >= 3) break;
                end
                #1;
                @(posedge clk); #1;
                exp_c = model_read(0, 2, 0);
                addr = addr_of(0, 2, 0); rd_en = 1'b1;
                lat = 0; got = 0;
                for (int c = 0; c < 20; c++) begin
                    @(posedge clk); #1;
                    lat++;
                    if (ack_v[0]) begin d = rd0; got = 1; break; end
                end
                rd_en = 1'b0;
                $display("read  contention data=0x%0h lat=%0d", d, lat);
                check("contention_ack", got, 1);
                check("contention_latency", lat, 2);
                check("contention_data", d, exp_c);
            end
        join
        check("contention_accepts", acc_cnt, 10);
        for (int i = 0; i < acc_cnt; i++) model_inc(0, 7, 1);
        do_read(0, 7, 0, d, lat);
        check("contention_total_lo", d, 10);
        do_read(0, 7, 1, d, lat);
        check("contention_total_hi", d, 0);
        void'(model_read(0, 7, 0));
        void'(model_read(0, 7, 1));

        // randomized mix against the model
        for (int k = 0; k < 300; k++) begin
            int inst = ($urandom_range(0, 1) == 0) ? 0 : 2;
            int idx  = $urandom_range(0, 7);
            if ($urandom_range(0, 9) < 6) begin
                longint unsigned v = (inst == 0) ? longint'($urandom_range(0, 65535))
                                                 : longint'($urandom);
                do_inc(inst, idx, v);
                $display("inc   inst=%0d id=%0d val=0x%0h", inst, idx, v);
            end else begin
                read_check(inst, idx, $urandom_range(0, 1), "rand_read");
            end
        end

        // reset in the middle of an update
        sel = 0; tid = 5'd9; tdata = 32'h55; tvalid = 1'b1; got = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (tready_v[0]) begin got = 1; break; end
        end
        check("midwr_accept", got, 1);
        @(posedge clk); #1;
        rst_n = 1'b0; tvalid = 1'b0;
        #1;
        check_reset_outputs("midwr_reset");
        model_clear();
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        // read requested during INIT waits until the sweep completes
        addr = addr_of(0, 4, 1); rd_en = 1'b1; n = 0; got = 0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #1;
            n++;
            if (n == 5) begin
                check("init_wait", wait_v[0], 1);
                check("init_no_ack", ack_v[0], 0);
            end
            if (ack_v[0]) begin d = rd0; got = 1; break; end
        end
        rd_en = 1'b0;
        $display("read  during-init data=0x%0h cycles=%0d", d, n);
        check("init_read_ack", got, 1);
        check("init_read_cycles", n, 34);
        check("init_read_data", d, model_read(0, 4, 1));
        sweep_zero("rerun_zero");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
